spart_mm: RTL and testbench

Memory-mapped serial port (SPART: 8N1 UART) on the CPU's peripheral bus. It decodes four word addresses in the memory-mapped region (0x2000–0xFFFF), next to the LED (0xC001) and switch ports. It runs a programmable-baud transmitter and receiver, and returns read data that the top level ORs into the CPU `rdata` path. Bus access and all internal state are clocked on the falling edge of `clk`, matching the other memory-mapped peripherals.

---
 rtl/spart_pkg.sv | 34 +++
 rtl/spart_rx.sv | 107 ++++++++++
 rtl/spart_mm.sv | 191 +++++++++++++++++++
 tb/tb_spart_mm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the memory-mapped SPART (8N1 UART): register offsets,
// status bit positions, FSM state types and the baud-divisor clamp.
package spart_pkg;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_DBL  = 2'd2;
  localparam logic [1:0] OFF_DBH  = 2'd3;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FRM_ERR  = 3;

  localparam logic [15:0] DB_MIN = 16'd16;

  typedef enum logic {
    TX_IDLE,
    TX_XMIT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Divisors below DB_MIN are too short to sample mid-bit reliably.
  function automatic logic [15:0] eff_div(input logic [15:0] db);
    return (db < DB_MIN) ? DB_MIN : db;
  endfunction

endpackage

// File: rtl/spart_rx.sv
// SPART receiver: RX synchronizer, start/data/stop FSM and bit timer.
// rx_done/rx_ferr pulse on the stop-sample edge; rx_byte holds the shifted data.
module spart_rx
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div,
  input  logic        RX,
  output logic [7:0]  rx_byte,
  output logic        rx_done,
  output logic        rx_ferr
);

  rx_state_t   state_r, state_s;
  logic        sync1_r, sync2_r, prev_r;
  logic [15:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  shift_r, shift_s;
  logic        done_s, ferr_s, tick_s;

  assign tick_s  = (cnt_r == 16'd0);
  assign rx_byte = shift_r;
  assign rx_done = done_s;
  assign rx_ferr = ferr_s;

  // Next-state, bit timer and shifter for the receive FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    done_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (prev_r && !sync2_r) begin
          state_s = RX_START;
          cnt_s   = (div >> 1) - 16'd1;
        end else begin
          state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_s) begin
          if (sync2_r) begin
            state_s = RX_IDLE;
          end else begin
            state_s = RX_DATA;
            cnt_s   = div - 16'd1;
            idx_s   = 3'd0;
          end
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      RX_DATA: begin
        if (tick_s) begin
          shift_s = {sync2_r, shift_r[7:1]};
          cnt_s   = div - 16'd1;
          if (idx_r == 3'd7) begin
            state_s = RX_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      RX_STOP: begin
        if (tick_s) begin
          state_s = RX_IDLE;
          if (sync2_r) begin
            done_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      default: state_s = RX_IDLE;
    endcase
  end

  // Synchronizer, edge history and FSM registers (falling-edge domain).
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      state_r <= RX_IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      sync1_r <= RX;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
    end
  end

endmodule

// File: rtl/spart_mm.sv
// Memory-mapped SPART: bus decode of BASE..BASE+3, baud divisor, transmitter
// FSM and RX status flags. All state changes on the falling edge of clk.
module spart_mm
  import spart_pkg::*;
#(
  parameter logic [15:0] BASE   = 16'hC004,
  parameter logic [15:0] DB_RST = 16'd5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [15:0] rdata,
  input  logic        RX,
  output logic        TX
);

  logic [15:0] off_s, div_s;
  logic [1:0]  reg_s;
  logic        hit_s, we_s, re_s, rd_data_s, rd_stat_s, tx_ready_s;
  logic [7:0]  rx_byte_s;
  logic        rx_done_s, rx_ferr_s, unused_s;

  tx_state_t   tx_state_r, tx_state_s;
  logic [15:0] db_r, db_s, tx_cnt_r, tx_cnt_s, rdata_r, rdata_s, stat_s;
  logic [8:0]  tx_shift_r, tx_shift_s;
  logic [3:0]  tx_bits_r, tx_bits_s;
  logic [7:0]  rx_data_r, rx_data_s;
  logic        tx_line_r, tx_line_s;
  logic        rx_valid_r, rx_valid_s, overrun_r, overrun_s, frm_err_r, frm_err_s;

  assign off_s      = addr - BASE;
  assign hit_s      = (|addr[15:13]) && (off_s < 16'd4);
  assign reg_s      = off_s[1:0];
  assign we_s       = we && hit_s;
  assign re_s       = re && hit_s;
  assign rd_data_s  = re_s && (reg_s == OFF_DATA);
  assign rd_stat_s  = re_s && (reg_s == OFF_STAT);
  assign div_s      = eff_div(db_r);
  assign tx_ready_s = (tx_state_r == TX_IDLE);
  assign unused_s   = ^wdata[15:8];
  assign TX         = tx_line_r;
  assign rdata      = rdata_r;

  spart_rx u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div_s),
    .RX      (RX),
    .rx_byte (rx_byte_s),
    .rx_done (rx_done_s),
    .rx_ferr (rx_ferr_s)
  );

  // Register writes, transmit FSM, status flag updates and read mux.
  always_comb begin
    db_s       = db_r;
    tx_state_s = tx_state_r;
    tx_shift_s = tx_shift_r;
    tx_bits_s  = tx_bits_r;
    tx_cnt_s   = tx_cnt_r;
    tx_line_s  = tx_line_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = rx_valid_r;
    overrun_s  = overrun_r;
    frm_err_s  = frm_err_r;
    rdata_s    = 16'h0000;
    stat_s     = 16'h0000;

    if (we_s && (reg_s == OFF_DBL)) begin
      db_s[7:0] = wdata[7:0];
    end else if (we_s && (reg_s == OFF_DBH)) begin
      db_s[15:8] = wdata[7:0];
    end else begin
      db_s = db_r;
    end

    // Shifter holds {stop, data}; the start bit goes straight to the line.
    case (tx_state_r)
      TX_IDLE: begin
        if (we_s && (reg_s == OFF_DATA)) begin
          tx_state_s = TX_XMIT;
          tx_line_s  = 1'b0;
          tx_shift_s = {1'b1, wdata[7:0]};
          tx_bits_s  = 4'd9;
          tx_cnt_s   = div_s - 16'd1;
        end else begin
          tx_line_s = 1'b1;
        end
      end
      TX_XMIT: begin
        if (tx_cnt_r == 16'd0) begin
          if (tx_bits_r == 4'd0) begin
            tx_state_s = TX_IDLE;
            tx_line_s  = 1'b1;
          end else begin
            tx_line_s  = tx_shift_r[0];
            tx_shift_s = {1'b1, tx_shift_r[8:1]};
            tx_bits_s  = tx_bits_r - 4'd1;
            tx_cnt_s   = div_s - 16'd1;
          end
        end else begin
          tx_cnt_s = tx_cnt_r - 16'd1;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_line_s  = 1'b1;
      end
    endcase

    // A data read on the completion edge frees the holding register for the new byte.
    if (rx_done_s) begin
      if (rx_valid_r && !rd_data_s) begin
        overrun_s = 1'b1;
      end else begin
        rx_data_s  = rx_byte_s;
        rx_valid_s = 1'b1;
      end
    end else if (rd_data_s) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
    end

    if (rx_done_s && rx_valid_r && !rd_data_s) begin
      overrun_s = 1'b1;
    end else if (rd_stat_s) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end

    if (rx_ferr_s) begin
      frm_err_s = 1'b1;
    end else if (rd_stat_s) begin
      frm_err_s = 1'b0;
    end else begin
      frm_err_s = frm_err_r;
    end

    stat_s[ST_TX_READY] = tx_ready_s;
    stat_s[ST_RX_VALID] = rx_valid_r;
    stat_s[ST_OVERRUN]  = overrun_r;
    stat_s[ST_FRM_ERR]  = frm_err_r;

    if (re_s) begin
      case (reg_s)
        OFF_DATA: rdata_s = {8'h00, rx_data_r};
        OFF_STAT: rdata_s = stat_s;
        OFF_DBL:  rdata_s = {8'h00, db_r[7:0]};
        OFF_DBH:  rdata_s = {8'h00, db_r[15:8]};
        default:  rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  // State registers; reset forces the line idle immediately.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r       <= DB_RST;
      tx_state_r <= TX_IDLE;
      tx_shift_r <= 9'h1FF;
      tx_bits_r  <= 4'd0;
      tx_cnt_r   <= 16'd0;
      tx_line_r  <= 1'b1;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      rdata_r    <= 16'h0000;
    end else begin
      db_r       <= db_s;
      tx_state_r <= tx_state_s;
      tx_shift_r <= tx_shift_s;
      tx_bits_r  <= tx_bits_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_line_r  <= tx_line_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      overrun_r  <= overrun_s;
      frm_err_r  <= frm_err_s;
      rdata_r    <= rdata_s;
    end
  end

endmodule

// File: tb/tb_spart_mm.sv
// Self-checking bench for spart_mm: bus reads go through an expected-value
// queue; serial frames are driven and sampled on posedges, away from the DUT edge.
module tb_spart_mm;

  localparam logic [15:0] BASE   = 16'hC004;
  localparam logic [15:0] DB_RST = 16'd5208;

  logic        clk, rst_n, we, re, RX, TX;
  logic [15:0] addr, wdata, rdata;
  logic [15:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  spart_mm #(.BASE(BASE), .DB_RST(DB_RST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .RX    (RX),
    .TX    (TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp,
                          output logic [15:0] got, output logic [15:0] want);
    @(posedge clk);
    addr = a; re = 1'b1; exp_q.push_back(exp);
    @(posedge clk);
    got = rdata; want = exp_q.pop_front();
    re = 1'b0; addr = 16'h0000;
  endtask

  // Drives one 16-clk-per-bit frame; optional TX write and data read at given bit-clock indices.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int tx_at,
                            input int rd_at, input logic [15:0] rd_exp,
                            output logic [15:0] got, output logic [15:0] want);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    got = 16'h0000; want = 16'h0000;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      RX = frame[i/16];
      if (tx_at >= 0 && i == tx_at) begin addr = BASE; wdata = 16'h0055; we = 1'b1; end
      if (tx_at >= 0 && i == tx_at + 1) begin we = 1'b0; addr = 16'h0000; end
      if (rd_at >= 0 && i == rd_at) begin addr = BASE; re = 1'b1; exp_q.push_back(rd_exp); end
      if (rd_at >= 0 && i == rd_at + 1) begin
        got = rdata; want = exp_q.pop_front(); re = 1'b0; addr = 16'h0000;
      end
    end
    @(posedge clk);
    RX = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] g, w;
    logic [15:0] offs [3];
    logic [15:0] exps [3];
    offs = '{16'd1, 16'd2, 16'd3};
    exps = '{16'h0001, {8'h00, DB_RST[7:0]}, {8'h00, DB_RST[15:8]}};
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 16'h0000; wdata = 16'h0000; RX = 1'b1;
    repeat (3) @(posedge clk);
    tests++;
    if (TX !== 1'b1 || rdata !== 16'h0000) begin
      fails++; $display("FAIL reset_outputs: TX=%b rdata=%h, need TX=1 rdata=0000", TX, rdata);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + offs[k], exps[k], g, w);
      tests++;
      if (g !== w) begin fails++; $display("FAIL reset_reg%0d: got %h expected %h", k + 1, g, w); end
    end
  endtask

  task automatic test_decode();
    logic [15:0] g, w;
    bus_read(BASE + 16'd4, 16'h0000, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL decode_above: got %h expected %h", g, w); end
    bus_read(BASE - 16'd1, 16'h0000, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL decode_below: got %h expected %h", g, w); end
    bus_write(BASE + 16'd1, 16'hFFFF);
    bus_write(BASE + 16'd4, 16'h0000);
    bus_read(BASE + 16'd1, 16'h0001, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL decode_nowrite: status %h expected %h", g, w); end
    bus_write(BASE + 16'd2, 16'h0010);
    bus_write(BASE + 16'd3, 16'h0000);
    bus_read(BASE + 16'd2, 16'h0010, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL db_low_rb: got %h expected %h", g, w); end
  endtask

  task automatic test_transmit();
    logic [9:0]  frame;
    logic        exp_tx;
    logic [15:0] g, w;
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(BASE, 16'h00A5);
    for (int i = 0; i < 172; i++) begin
      exp_tx = (i < 160) ? frame[i/16] : 1'b1;
      tests++;
      if (TX !== exp_tx) begin fails++; $display("FAIL tx_bit clk %0d: TX=%b expected %b", i, TX, exp_tx); end
      if (i == 56) begin addr = BASE; wdata = 16'h0000; we = 1'b1; end
      if (i == 57) begin we = 1'b0; addr = 16'h0000; end
      if (i == 159) begin addr = BASE + 16'd1; re = 1'b1; exp_q.push_back(16'h0000); end
      if (i == 160 || i == 161) begin
        g = rdata; w = exp_q.pop_front();
        tests++;
        if (g !== w) begin fails++; $display("FAIL tx_ready clk %0d: status %h expected %h", i, g, w); end
        if (i == 160) exp_q.push_back(16'h0001);
        else begin re = 1'b0; addr = 16'h0000; end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_receive();
    logic [15:0] g, w;
    send_frame(8'h3C, 1'b1, 100, -1, 16'h0000, g, w);
    bus_read(BASE + 16'd1, 16'h0002, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL rx_status: got %h expected %h", g, w); end
    bus_read(BASE, 16'h003C, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL rx_data: got %h expected %h", g, w); end
    repeat (150) @(posedge clk);
    bus_read(BASE + 16'd1, 16'h0001, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL rx_status_after: got %h expected %h", g, w); end
  endtask

  task automatic test_overrun();
    logic [15:0] g, w;
    logic [15:0] adrs [4];
    logic [15:0] exps [4];
    adrs = '{BASE + 16'd1, BASE + 16'd1, BASE, BASE + 16'd1};
    exps = '{16'h0007, 16'h0003, 16'h0011, 16'h0001};
    send_frame(8'h11, 1'b1, -1, -1, 16'h0000, g, w);
    send_frame(8'h22, 1'b1, -1, -1, 16'h0000, g, w);
    for (int k = 0; k < 4; k++) begin
      bus_read(adrs[k], exps[k], g, w);
      tests++;
      if (g !== w) begin fails++; $display("FAIL overrun_step%0d: got %h expected %h", k, g, w); end
    end
  endtask

  task automatic test_errors();
    logic [15:0] g, w;
    @(posedge clk);
    RX = 1'b0;
    repeat (4) @(posedge clk);
    RX = 1'b1;
    repeat (40) @(posedge clk);
    bus_read(BASE + 16'd1, 16'h0001, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL false_start: status %h expected %h", g, w); end
    send_frame(8'h81, 1'b0, -1, -1, 16'h0000, g, w);
    bus_read(BASE + 16'd1, 16'h0009, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL frame_err: status %h expected %h", g, w); end
    bus_read(BASE + 16'd1, 16'h0001, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL frame_err_clear: status %h expected %h", g, w); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g, w;
    send_frame(8'h5A, 1'b1, -1, -1, 16'h0000, g, w);
    send_frame(8'hC3, 1'b1, -1, 154, 16'h005A, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL coincident_read: got %h expected %h", g, w); end
    bus_read(BASE + 16'd1, 16'h0003, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL coincident_status: got %h expected %h", g, w); end
    bus_read(BASE, 16'h00C3, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL coincident_newbyte: got %h expected %h", g, w); end
  endtask

  task automatic test_clamp();
    logic [15:0] g, w;
    logic        exp_tx;
    bus_write(BASE + 16'd2, 16'h0005);
    bus_read(BASE + 16'd2, 16'h0005, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL clamp_rb: got %h expected %h", g, w); end
    bus_write(BASE, 16'h000F);
    for (int i = 0; i < 32; i++) begin
      exp_tx = (i < 16) ? 1'b0 : 1'b1;
      tests++;
      if (TX !== exp_tx) begin fails++; $display("FAIL clamp_bit clk %0d: TX=%b expected %b", i, TX, exp_tx); end
      @(posedge clk);
    end
    repeat (140) @(posedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] g, w;
    bus_write(BASE, 16'h0000);
    repeat (20) @(posedge clk);
    tests++;
    if (TX !== 1'b0) begin fails++; $display("FAIL midframe_pre: TX=%b expected 0", TX); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (TX !== 1'b1) begin fails++; $display("FAIL midframe_reset: TX=%b expected 1", TX); end
    @(posedge clk);
    rst_n = 1'b1;
    bus_read(BASE + 16'd1, 16'h0001, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL midframe_status: got %h expected %h", g, w); end
    bus_read(BASE + 16'd2, {8'h00, DB_RST[7:0]}, g, w);
    tests++;
    if (g !== w) begin fails++; $display("FAIL midframe_db: got %h expected %h", g, w); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_transmit();
    test_receive();
    test_overrun();
    test_errors();
    test_back_to_back();
    test_clamp();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
